cin_autotrain: RTL and testbench

CIN_AUTOTRAIN -- requirements
Module: cin_autotrain

---
 rtl/cin_autotrain.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_cin_autotrain.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cin_autotrain.sv
// cin_autotrain: sequential per-lane IDELAY eye scan plus ISERDES word alignment
// for CIN-style deserialized lanes.
//   - Each lane's IDELAY is swept 0..2^DLY_BITS-1; every tap is graded with a
//     period check (data must repeat every 32/NBITS cycles and must not be constant).
//   - The longest run of good taps is chosen and its centre tap is loaded.
//   - Bitslip is pulsed until TRAIN_SEQUENCE appears on an NBITS-aligned slice.
// Optional feature: define CIN_AUTOTRAIN_MONITOR_EN to keep a period check on
// all lanes while parked in DONE, reporting errors on lane_err_o.
module cin_autotrain #(
  parameter int          NLANES         = 1,
  parameter int          NBITS          = 4,
  parameter int          DLY_BITS       = 6,
  parameter int          WINDOW_LOG2    = 8,
  parameter int          SETTLE         = 16,
  parameter int          MIN_EYE        = 4,
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996
) (
  input  logic                         sysclk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [NLANES*NBITS-1:0]      lane_data_i,
  output logic [NLANES-1:0]            idelay_load_o,
  output logic [DLY_BITS-1:0]          idelay_value_o,
  output logic [NLANES-1:0]            bitslip_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         fail_o,
  output logic [2:0]                   fail_lane_o,
  output logic [NLANES*DLY_BITS-1:0]   eye_start_o,
  output logic [NLANES*(DLY_BITS+1)-1:0] eye_len_o,
  output logic [NLANES*5-1:0]          nyb_phase_o,
  output logic [NLANES-1:0]            lane_err_o
);

  localparam int P  = 32 / NBITS;   // words per training-word period
  localparam int HW = 64;           // history width: 2P words of NBITS bits
  localparam int CW = 24;           // shared cycle counter width
  localparam int LW = DLY_BITS + 1; // eye length width

  localparam logic [CW-1:0]       WIN_LAST    = CW'((2 ** WINDOW_LOG2) - 1);
  localparam logic [CW-1:0]       SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0]       ALIGN_LAST  = CW'(2 * P - 1);
  localparam logic [CW-1:0]       CNT_ONE     = CW'(1);
  localparam logic [6:0]          FILL_FULL   = 7'(2 * P);
  localparam logic [DLY_BITS-1:0] TAP_MAX     = '1;
  localparam logic [DLY_BITS-1:0] TAP_ONE     = DLY_BITS'(1);
  localparam logic [LW-1:0]       LEN_ONE     = LW'(1);
  localparam logic [LW-1:0]       MIN_EYE_L   = LW'(MIN_EYE);
  localparam logic [2:0]          LAST_LANE   = 3'(NLANES - 1);
  localparam logic [5:0]          SLIP_MAX    = 6'(NBITS);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_WAIT   = 4'd2;
  localparam logic [3:0] S_MEAS   = 4'd3;
  localparam logic [3:0] S_EVAL   = 4'd4;
  localparam logic [3:0] S_CENTER = 4'd5;
  localparam logic [3:0] S_ALIGN  = 4'd6;
  localparam logic [3:0] S_SLIP   = 4'd7;
  localparam logic [3:0] S_NEXT   = 4'd8;
  localparam logic [3:0] S_DONE   = 4'd9;
  localparam logic [3:0] S_FAIL   = 4'd10;

  logic [3:0]          state;
  logic                to_align;     // settle wait returns to ALIGN instead of MEAS
  logic [CW-1:0]       cnt;
  logic [DLY_BITS-1:0] tap;
  logic [2:0]          lane;
  logic [5:0]          slip_cnt;
  logic [HW-1:0]       hist;         // newest word in the low NBITS bits
  logic [6:0]          fill;
  logic                bad_seen;
  logic                nonconst;
  logic [NBITS-1:0]    first_word;
  logic [DLY_BITS-1:0] cur_start;
  logic [LW-1:0]       cur_len;
  logic [DLY_BITS-1:0] best_start;
  logic [LW-1:0]       best_len;

  logic [NBITS-1:0]    sel_data;
  logic [NLANES-1:0]   lane_onehot;
  logic                strobe_any;
  logic                hist_full;
  logic                bad_now;
  logic                found;
  logic [4:0]          phase;
  logic                good;
  logic [LW-1:0]       run_len;
  logic [DLY_BITS-1:0] run_start;
  logic                run_close;
  logic [LW-1:0]       best_len_nx;
  logic [DLY_BITS-1:0] best_start_nx;
  logic [DLY_BITS-1:0] center;

  // Selected-lane data, strobe mask and the period check on that lane
  always_comb begin
    sel_data   = lane_data_i[lane*NBITS +: NBITS];
    lane_onehot = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_onehot[i] = (lane == 3'(i));
    end
    strobe_any = (|idelay_load_o) | (|bitslip_o);
    hist_full  = (fill == FILL_FULL);
    bad_now    = hist_full && (sel_data != hist[(P-1)*NBITS +: NBITS]);
  end

  // Lowest NBITS-aligned slice of the history that holds the training word
  always_comb begin
    found = 1'b0;
    phase = 5'd0;
    for (int s = P - 1; s >= 0; s--) begin
      if (hist[s*NBITS +: 32] == TRAIN_SEQUENCE) begin
        found = 1'b1;
        phase = 5'(s);
      end else begin
        found = found;
        phase = phase;
      end
    end
  end

  // Run tracker: extend or close the current good-tap run; strict > keeps the first of a tie
  always_comb begin
    good          = ~bad_seen & nonconst;
    run_len       = good ? (cur_len + LEN_ONE) : cur_len;
    run_start     = (good && (cur_len == '0)) ? tap : cur_start;
    run_close     = ~good | (tap == TAP_MAX);
    best_len_nx   = best_len;
    best_start_nx = best_start;
    if (run_close && (run_len > best_len)) begin
      best_len_nx   = run_len;
      best_start_nx = run_start;
    end else begin
      best_len_nx   = best_len;
      best_start_nx = best_start;
    end
    center = best_start + best_len[DLY_BITS:1];
  end

  // Shift history of the selected lane; any load or slip flushes it
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hist <= '0;
      fill <= 7'd0;
    end else if (strobe_any) begin
      hist <= '0;
      fill <= 7'd0;
    end else begin
      hist <= {hist[HW-NBITS-1:0], sel_data};
      fill <= hist_full ? fill : (fill + 7'd1);
    end
  end

  // Training sequencer: tap sweep, eye selection, centring and word alignment
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state          <= S_IDLE;
      to_align       <= 1'b0;
      cnt            <= '0;
      tap            <= '0;
      lane           <= 3'd0;
      slip_cnt       <= 6'd0;
      bad_seen       <= 1'b0;
      nonconst       <= 1'b0;
      first_word     <= '0;
      cur_start      <= '0;
      cur_len        <= '0;
      best_start     <= '0;
      best_len       <= '0;
      idelay_load_o  <= '0;
      idelay_value_o <= '0;
      bitslip_o      <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      fail_o         <= 1'b0;
      fail_lane_o    <= 3'd0;
      eye_start_o    <= '0;
      eye_len_o      <= '0;
      nyb_phase_o    <= '0;
    end else begin
      idelay_load_o <= '0;
      bitslip_o     <= '0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start_i) begin
            state       <= S_LOAD;
            tap         <= '0;
            lane        <= 3'd0;
            cur_start   <= '0;
            cur_len     <= '0;
            best_start  <= '0;
            best_len    <= '0;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            fail_o      <= 1'b0;
            fail_lane_o <= 3'd0;
            eye_start_o <= '0;
            eye_len_o   <= '0;
            nyb_phase_o <= '0;
          end else begin
            state <= state;
          end
        end
        S_LOAD: begin
          idelay_load_o  <= lane_onehot;
          idelay_value_o <= tap;
          cnt            <= '0;
          to_align       <= 1'b0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == SETTLE_LAST) begin
            cnt      <= '0;
            bad_seen <= 1'b0;
            nonconst <= 1'b0;
            state    <= to_align ? S_ALIGN : S_MEAS;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_MEAS: begin
          bad_seen <= bad_seen | bad_now;
          if (cnt == '0) begin
            first_word <= sel_data;
          end else if (sel_data != first_word) begin
            nonconst <= 1'b1;
          end else begin
            nonconst <= nonconst;
          end
          if (cnt == WIN_LAST) begin
            cnt   <= '0;
            state <= S_EVAL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_EVAL: begin
          cur_len    <= good ? run_len : '0;
          cur_start  <= run_start;
          best_len   <= best_len_nx;
          best_start <= best_start_nx;
          if (tap == TAP_MAX) begin
            if (best_len_nx < MIN_EYE_L) begin
              state       <= S_FAIL;
              busy_o      <= 1'b0;
              fail_o      <= 1'b1;
              fail_lane_o <= lane;
            end else begin
              state <= S_CENTER;
              eye_start_o[lane*DLY_BITS +: DLY_BITS] <= best_start_nx;
              eye_len_o[lane*LW +: LW]               <= best_len_nx;
            end
          end else begin
            tap   <= tap + TAP_ONE;
            state <= S_LOAD;
          end
        end
        S_CENTER: begin
          idelay_load_o  <= lane_onehot;
          idelay_value_o <= center;
          cnt            <= '0;
          to_align       <= 1'b1;
          slip_cnt       <= 6'd0;
          state          <= S_WAIT;
        end
        S_ALIGN: begin
          if (cnt == ALIGN_LAST) begin
            cnt <= '0;
            if (found) begin
              nyb_phase_o[lane*5 +: 5] <= phase;
              state <= S_NEXT;
            end else if (slip_cnt == SLIP_MAX) begin
              state       <= S_FAIL;
              busy_o      <= 1'b0;
              fail_o      <= 1'b1;
              fail_lane_o <= lane;
            end else begin
              state <= S_SLIP;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_SLIP: begin
          bitslip_o <= lane_onehot;
          slip_cnt  <= slip_cnt + 6'd1;
          cnt       <= '0;
          to_align  <= 1'b1;
          state     <= S_WAIT;
        end
        S_NEXT: begin
          if (lane == LAST_LANE) begin
            state  <= S_DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            lane       <= lane + 3'd1;
            tap        <= '0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            state      <= S_LOAD;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef CIN_AUTOTRAIN_MONITOR_EN
  logic [HW-1:0] mon_hist [NLANES];
  logic [6:0]    mon_fill;

  // Post-training monitor: period check on every lane while in DONE, sticky per-lane error
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NLANES; k++) begin
        mon_hist[k] <= '0;
      end
      mon_fill   <= 7'd0;
      lane_err_o <= '0;
    end else if (start_i && ((state == S_DONE) || (state == S_FAIL))) begin
      mon_fill   <= 7'd0;
      lane_err_o <= '0;
    end else if (state == S_DONE) begin
      for (int k = 0; k < NLANES; k++) begin
        mon_hist[k] <= {mon_hist[k][HW-NBITS-1:0], lane_data_i[k*NBITS +: NBITS]};
        if ((mon_fill == FILL_FULL) &&
            (lane_data_i[k*NBITS +: NBITS] != mon_hist[k][(P-1)*NBITS +: NBITS])) begin
          lane_err_o[k] <= 1'b1;
        end else begin
          lane_err_o[k] <= lane_err_o[k];
        end
      end
      mon_fill <= (mon_fill == FILL_FULL) ? mon_fill : (mon_fill + 7'd1);
    end else begin
      mon_fill <= 7'd0;
    end
  end
`else
  assign lane_err_o = '0;
`endif

endmodule

// File: tb/tb_cin_autotrain.sv
// Directed bench for cin_autotrain: 4 lanes, NBITS=4, DLY_BITS=6, short window.
// A channel model turns each lane's IDELAY tap and bitslip count into data.
module tb_cin_autotrain;

  localparam logic [31:0] TRAIN = 32'hA55A6996;
  localparam logic [31:0] OTHER = 32'h12345678;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] lane_data;
  logic [3:0]  idelay_load;
  logic [5:0]  idelay_value;
  logic [3:0]  bitslip;
  logic        busy, done, fail;
  logic [2:0]  fail_lane;
  logic [23:0] eye_start;
  logic [27:0] eye_len;
  logic [19:0] nyb_phase;
  logic [3:0]  lane_err;

  cin_autotrain #(
    .NLANES(4), .NBITS(4), .DLY_BITS(6), .WINDOW_LOG2(4),
    .SETTLE(16), .MIN_EYE(4), .TRAIN_SEQUENCE(TRAIN)
  ) dut (
    .sysclk_i(clk), .rst_n_i(rst_n), .start_i(start), .lane_data_i(lane_data),
    .idelay_load_o(idelay_load), .idelay_value_o(idelay_value), .bitslip_o(bitslip),
    .busy_o(busy), .done_o(done), .fail_o(fail), .fail_lane_o(fail_lane),
    .eye_start_o(eye_start), .eye_len_o(eye_len), .nyb_phase_o(nyb_phase),
    .lane_err_o(lane_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // channel configuration (written by the stimulus process only)
  int          lo1[4], hi1[4], lo2[4], hi2[4], boff[4], slip_base[4];
  logic [31:0] pat[4];
  logic        inj;
  // channel state (written by the model process only)
  int          tap_m[4], slip_tot[4], load_tot[4], multi;
  int          tcnt;
  logic [5:0]  last_val[4];
  // snapshots
  int          ld_s[4], bs_s[4], multi_s;

  function automatic logic [3:0] chan_word(int k);
    logic [3:0] d;
    logic [31:0] w;
    int off;
    bit g;
    g = ((tap_m[k] >= lo1[k]) && (tap_m[k] <= hi1[k])) ||
        ((tap_m[k] >= lo2[k]) && (tap_m[k] <= hi2[k]));
    w = pat[k];
    off = boff[k] + slip_tot[k] - slip_base[k];
    d = 4'h0;
    if (g) begin
      for (int j = 0; j < 4; j++) d[3-j] = w[31 - ((tcnt*4 + off + j) % 32)];
    end else if ((tap_m[k] % 2) == 1) begin
      d = 4'(tcnt);
    end else begin
      d = 4'h0;
    end
    return d;
  endfunction

  // channel model: apply strobes seen at each edge, then present the next word
  initial begin
    tcnt = 0;
    multi = 0;
    lane_data = 16'h0;
    for (int k = 0; k < 4; k++) begin
      tap_m[k] = 0; slip_tot[k] = 0; load_tot[k] = 0; last_val[k] = 6'd0;
    end
    forever begin
      @(posedge clk);
      #1;
      if (($countones(idelay_load) + $countones(bitslip)) > 1) multi++;
      for (int k = 0; k < 4; k++) begin
        if (idelay_load[k]) begin
          tap_m[k] = int'(idelay_value);
          last_val[k] = idelay_value;
          load_tot[k]++;
        end
        if (bitslip[k]) slip_tot[k]++;
      end
      tcnt++;
      for (int k = 0; k < 4; k++) lane_data[k*4 +: 4] = chan_word(k);
      if (inj) lane_data[4] = ~lane_data[4];
    end
  end

  task automatic set_lane(int k, int a1, int b1, int a2, int b2, int off, logic [31:0] p);
    lo1[k] = a1; hi1[k] = b1; lo2[k] = a2; hi2[k] = b2;
    boff[k] = off; pat[k] = p; slip_base[k] = slip_tot[k];
  endtask

  task automatic default_lanes();
    for (int k = 0; k < 4; k++) set_lane(k, 10, 30, 100, 99, 0, TRAIN);
  endtask

  task automatic snap();
    for (int k = 0; k < 4; k++) begin ld_s[k] = load_tot[k]; bs_s[k] = slip_tot[k]; end
    multi_s = multi;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_end();
    int i;
    i = 0;
    while (!(done || fail) && (i < 20000)) begin @(negedge clk); i++; end
    n_cmp++;
    if (!(done || fail)) begin n_bad++; $display("FAIL timeout: got done|fail=0 expected 1 after %0d cycles", i); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; inj = 1'b0;
    default_lanes();
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, fail} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b expected 000", {busy, done, fail}); end
    n_cmp++; if (idelay_value !== 6'd0) begin n_bad++; $display("FAIL rst_value: got %0d expected 0", idelay_value); end
    n_cmp++; if ({eye_start, eye_len, nyb_phase, lane_err} !== 76'd0) begin n_bad++; $display("FAIL rst_results: got %h expected 0", {eye_start, eye_len, nyb_phase, lane_err}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({idelay_load, bitslip, busy} !== 9'd0) begin n_bad++; $display("FAIL idle_quiet: got %b expected 0", {idelay_load, bitslip, busy}); end
  endtask

  task automatic test_single_lane();
    default_lanes();
    set_lane(0, 20, 35, 100, 99, 2, TRAIN);
    snap();
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL s1_busy: got %b expected 1", busy); end
    wait_end();
    n_cmp++; if ({done, fail, busy} !== 3'b100) begin n_bad++; $display("FAIL s1_flags: got %b expected 100", {done, fail, busy}); end
    n_cmp++; if (eye_start[5:0] !== 6'd20) begin n_bad++; $display("FAIL s1_eye_start: got %0d expected 20", eye_start[5:0]); end
    n_cmp++; if (eye_len[6:0] !== 7'd16) begin n_bad++; $display("FAIL s1_eye_len: got %0d expected 16", eye_len[6:0]); end
    n_cmp++; if (load_tot[0] - ld_s[0] != 65) begin n_bad++; $display("FAIL s1_loads: got %0d expected 65", load_tot[0] - ld_s[0]); end
    n_cmp++; if (last_val[0] !== 6'd28) begin n_bad++; $display("FAIL s1_center: got %0d expected 28", last_val[0]); end
    n_cmp++; if (slip_tot[0] - bs_s[0] != 2) begin n_bad++; $display("FAIL s1_slips: got %0d expected 2", slip_tot[0] - bs_s[0]); end
    n_cmp++; if (slip_tot[1] - bs_s[1] != 0) begin n_bad++; $display("FAIL s1_slips_l1: got %0d expected 0", slip_tot[1] - bs_s[1]); end
    n_cmp++; if ({eye_start[11:6], eye_len[13:7]} !== {6'd10, 7'd21}) begin n_bad++; $display("FAIL s1_eye_l1: got %0d/%0d expected 10/21", eye_start[11:6], eye_len[13:7]); end
    n_cmp++; if (idelay_value !== 6'd20) begin n_bad++; $display("FAIL s1_hold_value: got %0d expected 20", idelay_value); end
    n_cmp++; if (multi != multi_s) begin n_bad++; $display("FAIL s1_one_strobe: got %0d expected %0d", multi, multi_s); end
  endtask

  task automatic test_tie_restart();
    default_lanes();
    set_lane(0, 5, 10, 40, 45, 0, TRAIN);
    snap();
    pulse_start();
    n_cmp++; if ({done, busy} !== 2'b01) begin n_bad++; $display("FAIL rs_flags: got %b expected 01", {done, busy}); end
    n_cmp++; if ({eye_start, eye_len} !== 52'd0) begin n_bad++; $display("FAIL rs_clear: got %h expected 0", {eye_start, eye_len}); end
    repeat (500) @(negedge clk);
    pulse_start();
    wait_end();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL tie_done: got %b expected 1", done); end
    n_cmp++; if ({eye_start[5:0], eye_len[6:0]} !== {6'd5, 7'd6}) begin n_bad++; $display("FAIL tie_eye: got %0d/%0d expected 5/6", eye_start[5:0], eye_len[6:0]); end
    n_cmp++; if (load_tot[0] - ld_s[0] != 65) begin n_bad++; $display("FAIL busy_start_ignored: got %0d loads expected 65", load_tot[0] - ld_s[0]); end
  endtask

  task automatic test_top_edge();
    default_lanes();
    set_lane(0, 60, 63, 100, 99, 0, TRAIN);
    snap();
    pulse_start();
    wait_end();
    n_cmp++; if ({done, fail} !== 2'b10) begin n_bad++; $display("FAIL top_flags: got %b expected 10", {done, fail}); end
    n_cmp++; if ({eye_start[5:0], eye_len[6:0]} !== {6'd60, 7'd4}) begin n_bad++; $display("FAIL top_eye: got %0d/%0d expected 60/4", eye_start[5:0], eye_len[6:0]); end
    n_cmp++; if (last_val[0] !== 6'd62) begin n_bad++; $display("FAIL top_center: got %0d expected 62", last_val[0]); end
    default_lanes();
    set_lane(0, 61, 63, 100, 99, 0, TRAIN);
    snap();
    pulse_start();
    wait_end();
    n_cmp++; if ({done, fail, busy} !== 3'b010) begin n_bad++; $display("FAIL small_flags: got %b expected 010", {done, fail, busy}); end
    n_cmp++; if (fail_lane !== 3'd0) begin n_bad++; $display("FAIL small_lane: got %0d expected 0", fail_lane); end
    n_cmp++; if (load_tot[1] - ld_s[1] != 0) begin n_bad++; $display("FAIL small_l1_loads: got %0d expected 0", load_tot[1] - ld_s[1]); end
  endtask

  task automatic test_no_match();
    default_lanes();
    set_lane(2, 10, 30, 100, 99, 0, OTHER);
    snap();
    pulse_start();
    wait_end();
    n_cmp++; if ({done, fail} !== 2'b01) begin n_bad++; $display("FAIL nm_flags: got %b expected 01", {done, fail}); end
    n_cmp++; if (fail_lane !== 3'd2) begin n_bad++; $display("FAIL nm_lane: got %0d expected 2", fail_lane); end
    n_cmp++; if (slip_tot[2] - bs_s[2] != 4) begin n_bad++; $display("FAIL nm_slips: got %0d expected 4", slip_tot[2] - bs_s[2]); end
    n_cmp++; if ((load_tot[3] - ld_s[3]) + (slip_tot[3] - bs_s[3]) != 0) begin n_bad++; $display("FAIL nm_l3_quiet: got %0d strobes expected 0", (load_tot[3] - ld_s[3]) + (slip_tot[3] - bs_s[3])); end
  endtask

  task automatic test_reset_mid();
    int i;
    logic [9:0] seen;
    default_lanes();
    set_lane(0, 20, 35, 100, 99, 2, TRAIN);
    snap();
    pulse_start();
    i = 0;
    while ((load_tot[0] < ld_s[0] + 2) && (i < 2000)) begin @(negedge clk); i++; end
    repeat (24) @(negedge clk);
    n_cmp++; if ({busy, idelay_value} !== {1'b1, 6'd1}) begin n_bad++; $display("FAIL mid_state: got %b/%0d expected 1/1", busy, idelay_value); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, fail, idelay_value} !== 9'd0) begin n_bad++; $display("FAIL async_rst: got %b expected 0", {busy, done, fail, idelay_value}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = '0;
    repeat (4) begin @(posedge clk); #1 seen = seen | {idelay_load, bitslip, busy, done}; end
    n_cmp++; if (seen !== 10'd0) begin n_bad++; $display("FAIL release_quiet: got %b expected 0", seen); end
    set_lane(0, 20, 35, 100, 99, 2, TRAIN);
    snap();
    pulse_start();
    wait_end();
    n_cmp++; if ({done, eye_start[5:0], eye_len[6:0]} !== {1'b1, 6'd20, 7'd16}) begin n_bad++; $display("FAIL retrain: got %b/%0d/%0d expected 1/20/16", done, eye_start[5:0], eye_len[6:0]); end
    n_cmp++; if (slip_tot[0] - bs_s[0] != 2) begin n_bad++; $display("FAIL retrain_slips: got %0d expected 2", slip_tot[0] - bs_s[0]); end
  endtask

  task automatic test_monitor();
    logic [3:0] exp_err;
`ifdef CIN_AUTOTRAIN_MONITOR_EN
    exp_err = 4'b0010;
`else
    exp_err = 4'b0000;
`endif
    repeat (40) @(negedge clk);
    n_cmp++; if (lane_err !== 4'b0000) begin n_bad++; $display("FAIL mon_clean: got %b expected 0000", lane_err); end
    @(posedge clk); #3 inj = 1'b1;
    @(posedge clk); #3 inj = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if (lane_err !== exp_err) begin n_bad++; $display("FAIL mon_flag: got %b expected %b", lane_err, exp_err); end
    repeat (40) @(negedge clk);
    n_cmp++; if (lane_err !== exp_err) begin n_bad++; $display("FAIL mon_hold: got %b expected %b", lane_err, exp_err); end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_tie_restart();
    test_top_edge();
    test_no_match();
    test_reset_mid();
    test_monitor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
